nn_stream: RTL and testbench



---
 rtl/nn_pkg.sv | 55 +++++
 rtl/nn_stream_sat_mac.sv | 31 +++
 rtl/nn_stream.sv | 161 ++++++++++++++++
 tb/tb_nn_stream.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared definitions for the nn_stream datapath.
//   MAX_POS / MIN_NEG : saturation limits for the default DATAWIDTH
//   sat_mul / sat_add : saturating arithmetic, width-generic up to MAX_W bits
//   state_t           : main FSM states
package nn_pkg;

    localparam int unsigned DATAWIDTH_DEF = 32;
    localparam logic signed [DATAWIDTH_DEF-1:0] MAX_POS = {1'b0, {(DATAWIDTH_DEF-1){1'b1}}};
    localparam logic signed [DATAWIDTH_DEF-1:0] MIN_NEG = {1'b1, {(DATAWIDTH_DEF-1){1'b0}}};

    // Operands are sign-extended into a fixed container so one function
    // body serves any datapath width up to MAX_W.
    localparam int unsigned MAX_W = 64;
    typedef logic signed [MAX_W-1:0]   word_t;
    typedef logic signed [2*MAX_W-1:0] wide_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Clamp v into the signed range of a w-bit word; ovf flags a clamp.
    function automatic word_t sat_clamp(input wide_t v, input int unsigned w, output logic ovf);
        wide_t hi;
        wide_t lo;
        hi  = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo  = -(wide_t'(1) <<< (w - 1));
        ovf = 1'b0;
        if (v > hi) begin
            ovf = 1'b1;
            return word_t'(hi);
        end
        if (v < lo) begin
            ovf = 1'b1;
            return word_t'(lo);
        end
        return word_t'(v);
    endfunction

    function automatic word_t sat_mul(input word_t a, input word_t b, input int unsigned w,
                                      output logic ovf);
        wide_t p;
        p = wide_t'(a) * wide_t'(b);
        return sat_clamp(p, w, ovf);
    endfunction

    function automatic word_t sat_add(input word_t a, input word_t b, input int unsigned w,
                                      output logic ovf);
        wide_t s;
        s = wide_t'(a) + wide_t'(b);
        return sat_clamp(s, w, ovf);
    endfunction

endpackage

// File: rtl/nn_stream_sat_mac.sv
// nn_sat_mac: combinational single neuron step.
//   x, w, b   : sample, weight, bias (signed)
//   acc       : running accumulator
//   acc_next  : sat(acc + relu(sat(sat(x*w) + b)))
//   ovf       : any of the three saturations clamped
module nn_sat_mac
    import nn_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DATAWIDTH_DEF
) (
    input  logic [DATAWIDTH-1:0] x,
    input  logic [DATAWIDTH-1:0] w,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] acc,
    output logic [DATAWIDTH-1:0] acc_next,
    output logic                 ovf
);

    word_t p, t, h, s;
    logic  ovf_p, ovf_t, ovf_s;

    always_comb begin
        p        = sat_mul(word_t'($signed(x)), word_t'($signed(w)), DATAWIDTH, ovf_p);
        t        = sat_add(p, word_t'($signed(b)), DATAWIDTH, ovf_t);
        h        = t[MAX_W-1] ? '0 : t;
        s        = sat_add(word_t'($signed(acc)), h, DATAWIDTH, ovf_s);
        acc_next = DATAWIDTH'(s);
        ovf      = ovf_p | ovf_t | ovf_s;
    end

endmodule

// File: rtl/nn_stream.sv
// nn_stream: streaming NUM_INPUTS-input neuron layer with a summing output.
//   clk, reset            : clock, async active-high reset
//   enable                : 0 freezes all state and masks in_ready/out_valid
//   in_valid/in_ready     : sample vector handshake, in_data packs x_i
//   cfg_we/addr/data      : weights (0..N-1), biases (N..2N-1), output bias (2N)
//   out_valid/out_ready   : result handshake; out_data, out_ovf, out_zero
//   total_ovf             : sticky overflow seen on any accepted result
//   ovf/zero_fsm_state    : consecutive overflow / zero result counters (sat at 7)
module nn_stream
    import nn_pkg::*;
#(
    parameter int unsigned DATAWIDTH  = DATAWIDTH_DEF,
    parameter int unsigned NUM_INPUTS = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_INPUTS*DATAWIDTH-1:0]   in_data,
    input  logic                              cfg_we,
    input  logic [$clog2(2*NUM_INPUTS+1)-1:0] cfg_addr,
    input  logic [DATAWIDTH-1:0]              cfg_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATAWIDTH-1:0]              out_data,
    output logic                              out_ovf,
    output logic                              out_zero,
    output logic                              total_ovf,
    output logic [2:0]                        ovf_fsm_state,
    output logic [2:0]                        zero_fsm_state
);

    localparam int unsigned AW = $clog2(2*NUM_INPUTS+1);
    localparam int unsigned IW = $clog2(NUM_INPUTS+1);

    state_t               state, state_nx;
    logic [IW-1:0]        idx, sel;
    logic [DATAWIDTH-1:0] x_reg [NUM_INPUTS];
    logic [DATAWIDTH-1:0] w_reg [NUM_INPUTS];
    logic [DATAWIDTH-1:0] b_reg [NUM_INPUTS];
    logic [DATAWIDTH-1:0] b_out, acc, mac_acc, y;
    logic                 ovf_lat, mac_ovf, y_ovf;
    logic                 idle_rdy, accept, last, handshake, cfg_ok;
    word_t                y_wide;

    // idx runs to N: the extra MAC step applies the output bias.
    always_comb sel = (idx < IW'(NUM_INPUTS)) ? idx : '0;

    nn_sat_mac #(.DATAWIDTH(DATAWIDTH)) u_mac (
        .x        (x_reg[sel]),
        .w        (w_reg[sel]),
        .b        (b_reg[sel]),
        .acc      (acc),
        .acc_next (mac_acc),
        .ovf      (mac_ovf)
    );

    always_comb begin
        y_wide = sat_add(word_t'($signed(acc)), word_t'($signed(b_out)), DATAWIDTH, y_ovf);
        y      = DATAWIDTH'(y_wide);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        idle_rdy  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        handshake = 1'b0;
        cfg_ok    = 1'b0;
        if (enable) begin
            unique case (state)
                IDLE: begin
                    idle_rdy = 1'b1;
                    cfg_ok   = cfg_we;
                    if (in_valid) begin
                        accept   = 1'b1;
                        state_nx = MAC;
                    end
                end
                MAC: begin
                    if (idx == IW'(NUM_INPUTS)) begin
                        last     = 1'b1;
                        state_nx = OUT;
                    end
                end
                OUT: begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        handshake = 1'b1;
                        state_nx  = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign in_ready = idle_rdy & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                x_reg[i] <= '0;
                w_reg[i] <= DATAWIDTH'(1);
                b_reg[i] <= '0;
            end
            b_out          <= '0;
            acc            <= '0;
            idx            <= '0;
            ovf_lat        <= 1'b0;
            out_data       <= '0;
            out_ovf        <= 1'b0;
            out_zero       <= 1'b0;
            total_ovf      <= 1'b0;
            ovf_fsm_state  <= '0;
            zero_fsm_state <= '0;
        end else if (enable) begin
            // A write in the accept cycle lands before MAC reads the bank,
            // so the accepted vector sees the new value.
            if (cfg_ok) begin
                for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                    if (cfg_addr == AW'(i))              w_reg[i] <= cfg_data;
                    if (cfg_addr == AW'(NUM_INPUTS + i)) b_reg[i] <= cfg_data;
                end
                if (cfg_addr == AW'(2*NUM_INPUTS)) b_out <= cfg_data;
            end
            if (accept) begin
                for (int unsigned i = 0; i < NUM_INPUTS; i++)
                    x_reg[i] <= in_data[i*DATAWIDTH +: DATAWIDTH];
                acc     <= '0;
                ovf_lat <= 1'b0;
                idx     <= '0;
            end
            if (state == MAC && !last) begin
                acc     <= mac_acc;
                ovf_lat <= ovf_lat | mac_ovf;
                idx     <= idx + IW'(1);
            end
            if (last) begin
                out_data <= y;
                out_ovf  <= ovf_lat | y_ovf;
                out_zero <= (y == '0);
            end
            if (handshake) begin
                total_ovf      <= total_ovf | out_ovf;
                ovf_fsm_state  <= !out_ovf ? 3'd0 :
                                  (ovf_fsm_state == 3'd7) ? 3'd7 : ovf_fsm_state + 3'd1;
                zero_fsm_state <= !out_zero ? 3'd0 :
                                  (zero_fsm_state == 3'd7) ? 3'd7 : zero_fsm_state + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_nn_stream.sv
module tb_nn_stream;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int AW  = 4;
    localparam int LAT = N + 2;   // enabled edges from accept edge (inclusive) to out_valid
    localparam longint MAXP = 64'sd2147483647;
    localparam longint MINN = -64'sd2147483648;

    logic           clk = 1'b0;
    logic           reset = 1'b1, enable = 1'b0, in_valid = 1'b0, cfg_we = 1'b0, out_ready = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic [AW-1:0]  cfg_addr = '0;
    logic [W-1:0]   cfg_data = '0;
    logic           in_ready, out_valid, out_ovf, out_zero, total_ovf;
    logic [W-1:0]   out_data;
    logic [2:0]     ovf_fsm_state, zero_fsm_state;

    always #5 clk = ~clk;

    nn_stream #(.DATAWIDTH(W), .NUM_INPUTS(N)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .out_zero(out_zero), .total_ovf(total_ovf),
        .ovf_fsm_state(ovf_fsm_state), .zero_fsm_state(zero_fsm_state)
    );

    typedef struct {
        longint y;
        bit     ovf;
        longint stamp;
    } item_t;

    longint mw [N];
    longint mb [N];
    longint mbout;
    int     m_ovfc, m_zeroc;
    bit     m_tot;
    item_t  q[$];
    item_t  pend;
    bit     pend_v;
    longint en_edges = 0;
    int     checks = 0, failures = 0;
    bit     acc_flag;
    longint last_y;
    bit     last_ovf;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL timeout %s at %0t", name, $time);
    endtask

    function automatic longint sat(input longint v, inout bit o);
        if (v > MAXP) begin o = 1'b1; return MAXP; end
        if (v < MINN) begin o = 1'b1; return MINN; end
        return v;
    endfunction

    function automatic void model(input longint xs[N], output longint y, output bit o);
        longint a, p, t;
        o = 1'b0;
        a = 0;
        for (int i = 0; i < N; i++) begin
            p = sat(xs[i] * mw[i], o);
            t = sat(p + mb[i], o);
            if (t < 0) t = 0;
            a = sat(a + t, o);
        end
        y = sat(a + mbout, o);
    endfunction

    task automatic reset_model();
        for (int i = 0; i < N; i++) begin
            mw[i] = 1;
            mb[i] = 0;
        end
        mbout   = 0;
        m_ovfc  = 0;
        m_zeroc = 0;
        m_tot   = 1'b0;
        q.delete();
        pend_v  = 1'b0;
    endtask

    task automatic apply_cfg(input logic [AW-1:0] a, input logic [W-1:0] d);
        longint v;
        v = longint'($signed(d));
        if (a < N)            mw[a] = v;
        else if (a < 2*N)     mb[a - N] = v;
        else if (a == 2*N)    mbout = v;
    endtask

    // Accepted vectors enter the scoreboard on the accepting edge.
    always @(posedge clk) begin
        if (enable && !reset) begin
            if (pend_v) begin
                pend.stamp = en_edges;
                q.push_back(pend);
                pend_v = 1'b0;
            end
            en_edges++;
        end
    end

    always @(negedge clk) begin
        bit ev;
        chk("in_ready", in_ready, (enable && !reset && q.size() == 0));
        chk("total_ovf", total_ovf, m_tot);
        chk("ovf_fsm_state", ovf_fsm_state, m_ovfc);
        chk("zero_fsm_state", zero_fsm_state, m_zeroc);
        ev = 1'b0;
        if (enable && !reset && q.size() != 0)
            if (en_edges - q[0].stamp >= LAT) ev = 1'b1;
        chk("out_valid", out_valid, ev);
        if (reset) begin
            chk("reset out_data", out_data, 0);
            chk("reset out_ovf", out_ovf, 0);
            chk("reset out_zero", out_zero, 0);
        end
        if (ev && out_valid) begin
            chk("out_data", $signed(out_data), q[0].y);
            chk("out_ovf", out_ovf, q[0].ovf);
            chk("out_zero", out_zero, (q[0].y == 0));
            if (out_ready) begin
                m_tot   = m_tot | q[0].ovf;
                m_ovfc  = !q[0].ovf ? 0 : (m_ovfc == 7 ? 7 : m_ovfc + 1);
                m_zeroc = (q[0].y != 0) ? 0 : (m_zeroc == 7 ? 7 : m_zeroc + 1);
                void'(q.pop_front());
            end
        end
    end

    // One clock cycle: inputs are already set (at posedge+1); the model
    // decides acceptance at posedge+4, then we move to the next posedge+1.
    task automatic tick();
        longint xs [N];
        longint y;
        bit     o;
        #3;
        acc_flag = 1'b0;
        if (enable && !reset && q.size() == 0) begin
            if (cfg_we) apply_cfg(cfg_addr, cfg_data);
            if (in_valid) begin
                for (int i = 0; i < N; i++) xs[i] = longint'($signed(in_data[i*W +: W]));
                model(xs, y, o);
                pend.y   = y;
                pend.ovf = o;
                pend.stamp = 0;
                pend_v   = 1'b1;
                acc_flag = 1'b1;
                last_y   = y;
                last_ovf = o;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] pack(input longint v[N]);
        logic [N*W-1:0] p;
        for (int i = 0; i < N; i++) p[i*W +: W] = v[i][W-1:0];
        return p;
    endfunction

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return $urandom();
            1:       return $urandom_range(0, 16) - 32'd8;
            2:       return 32'h4000_0000 + $urandom_range(0, 4) - 32'd2;
            default: return 32'hC000_0000 + $urandom_range(0, 4) - 32'd2;
        endcase
    endfunction

    task automatic set_cfg(input int a, input longint d);
        cfg_we   = 1'b1;
        cfg_addr = a[AW-1:0];
        cfg_data = d[W-1:0];
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic accept_vec(input longint v[N]);
        int guard;
        in_data  = pack(v);
        in_valid = 1'b1;
        guard    = 0;
        acc_flag = 1'b0;
        while (!acc_flag && guard < 20) begin
            tick();
            guard++;
        end
        in_valid = 1'b0;
        if (!acc_flag) timeout("accept");
    endtask

    task automatic drain(input int stall);
        int guard;
        guard = 0;
        if (stall > 0) begin
            out_ready = 1'b0;
            while (!(q.size() != 0 && en_edges - q[0].stamp >= LAT) && guard < 30) begin
                tick();
                guard++;
            end
            repeat (stall) tick();
        end
        out_ready = 1'b1;
        guard = 0;
        while ((q.size() != 0 || pend_v) && guard < 40) begin
            tick();
            guard++;
        end
        if (guard >= 40) timeout("drain");
    endtask

    task automatic send_vec(input longint v[N]);
        accept_vec(v);
        drain(0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        reset_model();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        longint v [N];
        reset_model();
        reset     = 1'b1;
        enable    = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tick();
        reset = 1'b0;
        tick();

        v = '{1, 2, 3, 4};
        send_vec(v);
        chk("pin defaults y", last_y, 10);
        chk("pin defaults ovf", last_ovf, 0);

        v = '{-5, 2, 0, 7};
        send_vec(v);
        chk("pin relu y", last_y, 9);
        chk("zero_fsm after nonzero", zero_fsm_state, 0);

        v = '{0, 0, 0, 0};
        send_vec(v);
        chk("pin zero y", last_y, 0);
        chk("zero_fsm after zero", zero_fsm_state, 1);

        set_cfg(0, 2);
        v = '{64'sd1073741824, 0, 0, 0};
        send_vec(v);
        chk("pin clamp y", last_y, 2147483647);
        chk("pin clamp ovf", last_ovf, 1);
        chk("total_ovf after clamp", total_ovf, 1);
        chk("ovf_fsm after 1", ovf_fsm_state, 1);
        repeat (7) send_vec(v);
        chk("ovf_fsm after 8", ovf_fsm_state, 7);
        set_cfg(0, 1);

        set_cfg(2*N, -10);
        v = '{3, 0, 0, 0};
        accept_vec(v);
        set_cfg(2*N, 100);
        drain(0);
        chk("pin bout y", last_y, -7);
        send_vec(v);
        chk("pin mac cfg dropped", last_y, -7);

        v = '{5, 6, 7, 8};
        accept_vec(v);
        drain(6);
        chk("pin stall y", last_y, 16);

        set_cfg(1, 3);
        v = '{1, 1, 1, 1};
        accept_vec(v);
        tick();
        do_reset();
        chk("in_ready after reset", in_ready, 1);
        chk("out_valid after reset", out_valid, 0);
        send_vec(v);
        chk("pin post-reset y", last_y, 4);

        for (int n = 0; n < 600; n++) begin
            enable    = ($urandom_range(0, 99) < 85);
            in_valid  = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < N; i++) in_data[i*W +: W] = rand_val();
            cfg_we    = ($urandom_range(0, 99) < 15);
            cfg_addr  = AW'($urandom_range(0, 15));
            cfg_data  = rand_val();
            out_ready = ($urandom_range(0, 99) < 65);
            if ($urandom_range(0, 199) == 0) do_reset();
            else tick();
        end

        enable   = 1'b1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        drain(0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
